// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and the data RAM: stores queue in a
// small FIFO and retire when the RAM port is idle; loads hitting a queued word stall.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              stallreq_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [3:0]        sel_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             hazard;
  logic             do_drain;
  logic             do_enq;
  logic             full;
  logic [PTR_W-1:0] offset;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  // An entry is live when its distance from head is below the count; sel is
  // deliberately ignored so any overlap with a buffered word forces a drain.
  always_comb begin
    hazard = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head_q;
      if ((CNT_W'(offset) < count_q) &&
          (addr_q[i][ADDR_W-1:2] == mem_addr_i[ADDR_W-1:2])) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard & mem_ce_i & ~mem_we_i & ~rst;
  end

  always_comb begin
    do_drain   = 1'b0;
    do_enq     = 1'b0;
    stallreq_o = 1'b0;
    mem_data_o = '0;
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;

    if (rst) begin
      do_drain = 1'b0;
    end else if (mem_ce_i && !mem_we_i) begin
      if (hazard) begin
        stallreq_o = 1'b1;
        do_drain   = 1'b1;
      end else begin
        ram_ce_o   = 1'b1;
        ram_addr_o = mem_addr_i;
        mem_data_o = ram_data_i;
      end
    end else if (mem_ce_i && mem_we_i) begin
      do_enq   = 1'b1;
      do_drain = full;
    end else begin
      do_drain = (count_q != '0);
    end

    if (do_drain) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = 1'b1;
      ram_addr_o = addr_q[head_q];
      ram_sel_o  = sel_q[head_q];
      ram_data_o = data_q[head_q];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_drain) head_d = head_q + PTR_W'(1);
    if (do_enq)   tail_d = tail_q + PTR_W'(1);
    if (do_enq && !do_drain)      count_d = count_q + CNT_W'(1);
    else if (!do_enq && do_drain) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: liveness is tracked solely by head and count.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      addr_q[tail_q] <= mem_addr_i;
      sel_q[tail_q]  <= mem_sel_i;
      data_q[tail_q] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and random stimulus for store_buffer, checked per cycle against a
// queue-of-pending-stores model plus a reference memory image.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ce_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] mem_data_o;
  logic        stallreq_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];
  ent_t        mq[$];
  logic [67:0] exp_q[$];
  logic [67:0] act_q[$];

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ce_i   (mem_ce_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_sel_i  (mem_sel_i),
    .mem_data_i (mem_data_i),
    .mem_data_o (mem_data_o),
    .stallreq_o (stallreq_o),
    .ram_ce_o   (ram_ce_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_sel_o  (ram_sel_o),
    .ram_data_o (ram_data_o),
    .ram_data_i (ram_data_i),
    .count_o    (count_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 8) return 32'hAAAA_AAAA;
    return 32'h5A00_0000 ^ (i * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] sel,
                                        input logic [31:0] data);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  // RAM: combinational read, byte-lane write on posedge; logs every write
  assign ram_data_i = ram_mem[ram_addr_o[9:2]];

  always begin
    for (int i = 0; i < 256; i++) ram_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (!rst && ram_ce_o && ram_we_o) begin
        ram_mem[ram_addr_o[9:2]] = merge(ram_mem[ram_addr_o[9:2]], ram_sel_o, ram_data_o);
        act_q.push_back({ram_addr_o, ram_sel_o, ram_data_o});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one cycle of MEM-stage request, checked against the model
  task automatic step(input logic ce, input logic we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] data, output logic stall);
    logic hz, wr, rd;
    ent_t h;
    @(negedge clk);
    mem_ce_i = ce; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
    #1;
    hz = 1'b0;
    foreach (mq[k]) if (ce && !we && mq[k].addr[31:2] == addr[31:2]) hz = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    if (ce && !we) begin
      if (hz) wr = 1'b1; else rd = 1'b1;
    end else if (ce && we) begin
      wr = (mq.size() == DEPTH);
    end else begin
      wr = (mq.size() != 0);
    end
    chk("count", 68'(count_o), 68'(mq.size()));
    chk("stall", 68'(stallreq_o), 68'(hz));
    h = (mq.size() != 0) ? mq[0] : '0;
    if (wr) begin
      chk("ram_ce", 68'(ram_ce_o), 68'(1));
      chk("ram_we", 68'(ram_we_o), 68'(1));
      chk("ram_wr", {ram_addr_o, ram_sel_o, ram_data_o}, 68'(h));
    end else if (rd) begin
      chk("ram_ce", 68'(ram_ce_o), 68'(1));
      chk("ram_we", 68'(ram_we_o), 68'(0));
      chk("ram_raddr", 68'(ram_addr_o), 68'(addr));
    end else begin
      chk("ram_ce", 68'(ram_ce_o), 68'(0));
      chk("ram_idle", {ram_we_o, ram_addr_o, ram_sel_o, ram_data_o}, 68'(0));
    end
    chk("mem_data", 68'(mem_data_o), rd ? 68'(ref_mem[addr[9:2]]) : 68'(0));
    if (wr) begin
      void'(mq.pop_front());
      ref_mem[h.addr[9:2]] = merge(ref_mem[h.addr[9:2]], h.sel, h.data);
    end
    if (ce && we) begin
      mq.push_back('{addr: addr, sel: sel, data: data});
      exp_q.push_back({addr, sel, data});
    end
    stall = hz;
  endtask

  task automatic do_load(input logic [31:0] addr, output int stalls, output logic [31:0] d);
    logic st;
    stalls = 0;
    d = '0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      step(1'b1, 1'b0, addr, 4'h0, 32'h0, st);
      if (!st) begin
        d = mem_data_o;
        break;
      end
      stalls++;
    end
  endtask

  task automatic drain();
    logic st;
    for (int c = 0; c < DEPTH + 2 && mq.size() != 0; c++) step(1'b0, 1'b0, '0, '0, '0, st);
  endtask

  // store presented during reset must be ignored; pending stores are discarded
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h3C; mem_sel_i = 4'hF; mem_data_i = 32'h1234_5678;
    #1;
    chk("rst_ram_ce", 68'(ram_ce_o), 68'(0));
    chk("rst_ram_out", {ram_we_o, ram_addr_o, ram_sel_o, ram_data_o}, 68'(0));
    chk("rst_stall", 68'(stallreq_o), 68'(0));
    chk("rst_mem_data", 68'(mem_data_o), 68'(0));
    for (int k = 0; k < mq.size(); k++) void'(exp_q.pop_back());
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    mem_ce_i = 1'b0;
    #1;
    chk("rst_count", 68'(count_o), 68'(0));
  endtask

  initial begin
    logic        st;
    int          n;
    logic [31:0] d;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    do_reset();

    // single store then idle retire, then read back
    step(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, st);
    step(1'b0, 1'b0, '0, '0, '0, st);
    chk("single_wr", {ram_we_o, ram_addr_o, ram_data_o}, {1'b1, 32'h10, 32'hDEAD_BEEF});
    do_load(32'h10, n, d);
    chk("single_rd", 68'(d), 68'(32'hDEAD_BEEF));
    chk("single_stalls", 68'(n), 68'(0));

    // fill, then a store into the full buffer retires the head in the same cycle
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(i * 4), 4'hF, $urandom, st);
    step(1'b1, 1'b1, 32'h100, 4'hF, 32'hCAFE_0100, st);
    chk("full_wr", {stallreq_o, ram_we_o, ram_addr_o}, {1'b0, 1'b1, 32'h0});
    chk("full_count", 68'(count_o), 68'(4));
    step(1'b0, 1'b0, '0, '0, '0, st);
    drain();

    // reset with three stores pending, then idle cycles issue no writes
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h80 + 32'(i * 4), 4'hF, $urandom, st);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, '0, st);

    // load hazard on a partial store
    step(1'b1, 1'b1, 32'h20, 4'b0011, 32'h1122_3344, st);
    step(1'b1, 1'b1, 32'h24, 4'hF, 32'h5555_6666, st);
    do_load(32'h20, n, d);
    chk("hz_stalls", 68'(n), 68'(1));
    chk("hz_data", 68'(d), 68'(32'hAAAA_3344));
    chk("hz_count", 68'(count_o), 68'(1));
    drain();

    // load to a neighbouring word of a buffered store
    step(1'b1, 1'b1, 32'h40, 4'hF, 32'h0BAD_F00D, st);
    do_load(32'h44, n, d);
    chk("nh_stalls", 68'(n), 68'(0));
    chk("nh_ram_we", 68'(ram_we_o), 68'(0));
    chk("nh_data", 68'(d), 68'(init_word(17)));
    chk("nh_count", 68'(count_o), 68'(1));
    drain();

    // ten stores with sparse idles so both pointers wrap twice
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 32'h200 + 32'(i * 4), 4'hF, 32'h7000_0000 + 32'(i), st);
      if (i % 3 == 2) step(1'b0, 1'b0, '0, '0, '0, st);
    end
    drain();
    step(1'b0, 1'b0, '0, '0, '0, st);
    chk("wrap_count", 68'(count_o), 68'(0));

    // random mix of stores, loads and idles over a small address window
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       step(1'b1, 1'b1, a, 4'($urandom_range(1, 15)), $urandom, st);
        1:       do_load(a, n, d);
        default: step(1'b0, 1'b0, '0, '0, '0, st);
      endcase
    end
    drain();
    step(1'b0, 1'b0, '0, '0, '0, st);

    // scoreboard: RAM writes must be exactly the surviving stores, in order
    @(posedge clk);
    #1;
    chk("wr_log_len", 68'(act_q.size()), 68'(exp_q.size()));
    while (exp_q.size() != 0 && act_q.size() != 0) chk("wr_log", act_q.pop_front(), exp_q.pop_front());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
